// File: rtl/ga25_vram_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ga25_vram_sched : 16-slot time-division scheduler for the GA25 VRAM port    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ga25_vram_sched #(
  parameter logic [14:0] OBJ_BASE  = 15'h7700,
  parameter logic [14:0] RS0_BASE  = 15'h7800,
  parameter logic [14:0] RS1_BASE  = 15'h7a00,
  parameter logic [14:0] SEL0_BASE = 15'h7c00,
  parameter logic [14:0] SEL1_BASE = 15'h7e00
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic        hpulse_i,
  input  logic [9:0]  ve_i,
  input  logic [9:0]  y_ofs0_i,
  input  logic [9:0]  y_ofs1_i,
  input  logic [14:0] layer_addr0_i,
  input  logic [14:0] layer_addr1_i,
  input  logic        mem_cs_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_din_i,
  output logic [15:0] cpu_dout_o,
  output logic        busy_o,
  output logic [14:0] vram_addr_o,
  output logic [15:0] vram_data_o,
  output logic        vram_we_o,
  input  logic [15:0] vram_q_i,
  output logic        ce_pix_o,
  output logic [3:0]  slot_o,
  output logic [9:0]  rowscroll0_o,
  output logic [9:0]  rowscroll1_o,
  output logic [9:0]  rowselect0_o,
  output logic [9:0]  rowselect1_o,
  output logic [15:0] index_latch_o,
  output logic [1:0]  layer_load_o,
  output logic [47:0] obj_data_o,
  output logic [2:0]  obj_sel_o
);

  typedef enum logic [1:0] {
    RQ_IDLE = 2'd0,
    RQ_DONE = 2'd1,
    RQ_PEND = 2'd2
  } rq_e;

  rq_e         rq_q, rq_d;
  logic [3:0]  slot_q, slot_d;
  logic        rs_active_q, rs_active_d;
  logic [14:0] obj_addr_q, obj_addr_d;
  logic        we_cap_q, we_cap_d;
  logic [15:0] din_cap_q, din_cap_d;
  logic        strb_prev_q, strb_prev_d;
  logic [14:0] vram_addr_q, vram_addr_d;
  logic [15:0] vram_data_q, vram_data_d;
  logic        vram_we_q, vram_we_d;
  logic [15:0] cpu_dout_q, cpu_dout_d;
  logic [9:0]  rowscroll0_q, rowscroll0_d;
  logic [9:0]  rowscroll1_q, rowscroll1_d;
  logic [9:0]  rowselect0_q, rowselect0_d;
  logic [9:0]  rowselect1_q, rowselect1_d;
  logic [15:0] index_latch_q, index_latch_d;
  logic [1:0]  layer_load_q, layer_load_d;
  logic [47:0] obj_data_q, obj_data_d;
  logic [2:0]  obj_sel_q, obj_sel_d;

  logic        w_strb;
  logic        w_capture;
  logic        w_ce_pix;
  logic [9:0]  w_sum0;
  logic [9:0]  w_sum1;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = cpu_addr_i[0];

  assign w_strb    = mem_cs_i & (mem_rd_i | mem_wr_i);
  assign w_capture = w_strb & ~strb_prev_q & (rq_q == RQ_IDLE);
  assign w_ce_pix  = ce_i & ~slot_q[0];
  assign w_sum0    = y_ofs0_i + ve_i;
  assign w_sum1    = y_ofs1_i + ve_i;

  // Addresses are registered on the ce that enters a slot so the VRAM sees
  // them for the whole slot; the read word is then consumed at the end of
  // the following slot.
  always_comb begin
    rq_d          = rq_q;
    slot_d        = slot_q;
    rs_active_d   = rs_active_q;
    obj_addr_d    = obj_addr_q;
    we_cap_d      = we_cap_q;
    din_cap_d     = din_cap_q;
    strb_prev_d   = w_strb;
    vram_addr_d   = vram_addr_q;
    vram_data_d   = vram_data_q;
    vram_we_d     = 1'b0;
    cpu_dout_d    = cpu_dout_q;
    rowscroll0_d  = rowscroll0_q;
    rowscroll1_d  = rowscroll1_q;
    rowselect0_d  = rowselect0_q;
    rowselect1_d  = rowselect1_q;
    index_latch_d = index_latch_q;
    layer_load_d  = layer_load_q;
    obj_data_d    = obj_data_q;
    obj_sel_d     = obj_sel_q;

    if (w_capture) begin
      rq_d      = RQ_PEND;
      we_cap_d  = mem_wr_i;
      din_cap_d = cpu_din_i;
    end

    if (ce_i) begin
      obj_sel_d = 3'b000;
      if (w_ce_pix) begin
        layer_load_d = 2'b00;
      end

      if (w_ce_pix && hpulse_i) begin
        slot_d      = 4'd15;
        rs_active_d = 1'b1;
        obj_addr_d  = OBJ_BASE;
      end else begin
        slot_d = slot_q + 4'd1;
      end

      case (slot_q)
        4'd1: begin
          if (rs_active_q) rowscroll0_d  = vram_q_i[9:0];
          else             index_latch_d = vram_q_i;
        end
        4'd2:  if (!rs_active_q) layer_load_d[0] = 1'b1;
        4'd3:  if (rs_active_q)  rowselect0_d    = vram_q_i[9:0];
        4'd5: begin
          obj_data_d[15:0] = vram_q_i;
          obj_sel_d[0]     = 1'b1;
          obj_addr_d       = obj_addr_q + 15'd1;
        end
        4'd7: begin
          obj_data_d[31:16] = vram_q_i;
          obj_sel_d[1]      = 1'b1;
          obj_addr_d        = obj_addr_q + 15'd1;
        end
        4'd9: begin
          if (rs_active_q) rowscroll1_d  = vram_q_i[9:0];
          else             index_latch_d = vram_q_i;
        end
        4'd10: if (!rs_active_q) layer_load_d[1] = 1'b1;
        4'd11: begin
          if (rs_active_q) rowselect1_d = vram_q_i[9:0];
          rs_active_d = 1'b0;
        end
        4'd13: begin
          obj_data_d[47:32] = vram_q_i;
          obj_sel_d[2]      = 1'b1;
          obj_addr_d        = obj_addr_q + 15'd1;
        end
        4'd15: begin
          cpu_dout_d = vram_q_i;
          if (rq_q == RQ_DONE) begin
            rq_d     = RQ_IDLE;
            we_cap_d = 1'b0;
          end
        end
        default: ;
      endcase

      case (slot_d)
        4'd0:  vram_addr_d = rs_active_q ? (RS0_BASE + {5'd0, w_sum0}) : layer_addr0_i;
        4'd2:  vram_addr_d = rs_active_q ? (SEL0_BASE + {7'd0, ve_i[7:0]})
                                         : (layer_addr0_i | 15'd1);
        4'd4:  vram_addr_d = obj_addr_d;
        4'd6:  vram_addr_d = obj_addr_d;
        4'd8:  vram_addr_d = rs_active_q ? (RS1_BASE + {5'd0, w_sum1}) : layer_addr1_i;
        4'd10: vram_addr_d = rs_active_q ? (SEL1_BASE + {7'd0, ve_i[7:0]})
                                         : (layer_addr1_i | 15'd1);
        4'd12: vram_addr_d = obj_addr_d;
        4'd14: begin
          // A strobe edge arriving on this very clk is serviced right away.
          vram_addr_d = cpu_addr_i[15:1];
          vram_data_d = w_capture ? cpu_din_i : din_cap_q;
          if (w_capture || rq_q == RQ_PEND) begin
            vram_we_d = w_capture ? mem_wr_i : we_cap_q;
            rq_d      = RQ_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rq_q          <= RQ_IDLE;
      slot_q        <= 4'd0;
      rs_active_q   <= 1'b0;
      obj_addr_q    <= OBJ_BASE;
      we_cap_q      <= 1'b0;
      din_cap_q     <= 16'd0;
      strb_prev_q   <= 1'b0;
      vram_addr_q   <= 15'd0;
      vram_data_q   <= 16'd0;
      vram_we_q     <= 1'b0;
      cpu_dout_q    <= 16'd0;
      rowscroll0_q  <= 10'd0;
      rowscroll1_q  <= 10'd0;
      rowselect0_q  <= 10'd0;
      rowselect1_q  <= 10'd0;
      index_latch_q <= 16'd0;
      layer_load_q  <= 2'b00;
      obj_data_q    <= 48'd0;
      obj_sel_q     <= 3'b000;
    end else begin
      rq_q          <= rq_d;
      slot_q        <= slot_d;
      rs_active_q   <= rs_active_d;
      obj_addr_q    <= obj_addr_d;
      we_cap_q      <= we_cap_d;
      din_cap_q     <= din_cap_d;
      strb_prev_q   <= strb_prev_d;
      vram_addr_q   <= vram_addr_d;
      vram_data_q   <= vram_data_d;
      vram_we_q     <= vram_we_d;
      cpu_dout_q    <= cpu_dout_d;
      rowscroll0_q  <= rowscroll0_d;
      rowscroll1_q  <= rowscroll1_d;
      rowselect0_q  <= rowselect0_d;
      rowselect1_q  <= rowselect1_d;
      index_latch_q <= index_latch_d;
      layer_load_q  <= layer_load_d;
      obj_data_q    <= obj_data_d;
      obj_sel_q     <= obj_sel_d;
    end
  end

  assign cpu_dout_o    = cpu_dout_q;
  assign busy_o        = (rq_q != RQ_IDLE);
  assign vram_addr_o   = vram_addr_q;
  assign vram_data_o   = vram_data_q;
  assign vram_we_o     = vram_we_q;
  assign ce_pix_o      = w_ce_pix;
  assign slot_o        = slot_q;
  assign rowscroll0_o  = rowscroll0_q;
  assign rowscroll1_o  = rowscroll1_q;
  assign rowselect0_o  = rowselect0_q;
  assign rowselect1_o  = rowselect1_q;
  assign index_latch_o = index_latch_q;
  assign layer_load_o  = layer_load_q;
  assign obj_data_o    = obj_data_q;
  assign obj_sel_o     = obj_sel_q;

endmodule
`default_nettype wire

// File: doc/ga25_vram_sched.md
Name: ga25_vram_sched

Overview:
- 16-slot time-division scheduler for the GA25 single-port 32Kx16 VRAM.
- Shares the one VRAM port between four requesters: the two tile-layer fetchers, per-line rowscroll/rowselect fetch, the sprite-list reader and the CPU.
- Generates the pixel enable and all load strobes that consumers use.
- Sits between the CPU bus / layer address generators and the VRAM macro.
- Replaces ad-hoc slot logic in the video top.

Parameters:
OBJ_BASE, 15'h7700, first VRAM word of sprite list, reloaded each line
RS0_BASE, 15'h7800, layer 0 rowscroll table base
RS1_BASE, 15'h7a00, layer 1 rowscroll table base
SEL0_BASE, 15'h7c00, layer 0 rowselect table base
SEL1_BASE, 15'h7e00, layer 1 rowselect table base

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce  in  1  13.33MHz clock enable
hpulse  in  1  line-start pulse, sampled on ce_pix
ve  in  10  effective vertical line (flip applied)
y_ofs0, y_ofs1  in  10 each  layer Y scroll
layer_addr0, layer_addr1  in  15 each  tile word address from each layer
mem_cs, mem_rd, mem_wr  in  1 each  CPU VRAM strobes
cpu_addr  in  16  CPU byte address; word = cpu_addr[15:1]
cpu_din  in  16  CPU write data
cpu_dout  out  16  CPU read data
busy  out  1  CPU access pending
vram_addr  out  15  VRAM address
vram_data  out  16  VRAM write data
vram_we  out  1  VRAM write enable
vram_q  in  16  VRAM read data, 1-clk registered latency
ce_pix  out  1  pixel enable = ce & ~slot[0]
slot  out  4  current slot
rowscroll0, rowscroll1, rowselect0, rowselect1  out  10 each  per-line registers
index_latch  out  16  tile index word
layer_load  out  2  per-layer attribute-valid strobe
obj_data  out  48  sprite entry words
obj_sel  out  3  sprite word-valid strobes

Behaviour:
- All state advances only on ce, except vram_we, which is a 1-clk pulse.
- Reset values:
  - slot=0, rs_active=0, obj_addr=OBJ_BASE, CPU rq=0.
  - vram_we=0, layer_load=0, obj_sel=0, busy=0.
  - All data registers and vram_addr=0.
- Slot counter: slot+1 mod 16 on each ce.
- On a ce_pix cycle with hpulse=1, slot forces to 15 instead of incrementing; rs_active<=1 and obj_addr<=OBJ_BASE.
- hpulse at any other time is ignored.
- obj_sel clears on every ce unless set in that slot.
- layer_load clears on every ce_pix unless set in that slot.
- Slot actions (addr issued in slot N, vram_q consumed in slot N+1):
  - 0: addr = rs_active ? RS0_BASE+(y_ofs0+ve) (10-bit sum, wraps) : layer_addr0.
  - 1: rs_active ? rowscroll0<=q[9:0] : index_latch<=q.
  - 2: addr = rs_active ? SEL0_BASE+ve[7:0] : layer_addr0|1, with layer_load[0]<=1 in the non-rowscroll case.
  - 3: if rs_active, rowselect0<=q[9:0].
  - 4: addr=obj_addr.
  - 5: obj_data[15:0]<=q, obj_sel[0]<=1, obj_addr+1.
  - 6: addr=obj_addr.
  - 7: obj_data[31:16]<=q, obj_sel[1]<=1, obj_addr+1.
  - 8-11: as 0-3 for layer 1, using RS1_BASE, SEL1_BASE, y_ofs1, layer_addr1 and layer_load[1]. Slot 11 also clears rs_active.
  - 12: addr=obj_addr.
  - 13: obj_data[47:32]<=q, obj_sel[2]<=1, obj_addr+1.
  - 14: addr=cpu_addr[15:1], vram_data=captured din, vram_we<=captured we; rq 2->1.
  - 15: cpu_dout<=q; rq 1->0 and captured we<=0.
- obj_addr wraps at 15 bits.
- CPU handshake:
  - Capture on the rising edge of mem_cs&(mem_rd|mem_wr), when busy=0: rq<=2, latch we=mem_wr and din.
  - Edge detection is evaluated every clk, not gated by ce.
  - busy = rq!=0.
  - An edge while busy is dropped; the CPU holds its strobes until busy falls, then a fresh edge is required.
  - A request captured after slot 14 has passed waits for the next slot 14. Worst case is 16 ce to rq=1 plus 1 ce to release.
  - cpu_dout is updated in every slot 15 regardless of rq; it holds the value read at the slot-14 address.
- Reset mid-access clears rq and vram_we immediately, and no write is committed after reset is seen.
- Simultaneous CPU edge and slot 14 in the same clk: the capture takes effect and the access is serviced in that slot 14.

Test Plan:
- Reset then free-run ce every clk -> slot cycles 0..15, ce_pix high on even slots only, obj_sel pulses in slots 6/8/14 (cycle after 5/7/13), busy=0.
- hpulse on ce_pix, ve=10, y_ofs0=3, y_ofs1=1023 -> vram_addr 0x780D in slot 0, 0x7C0A in slot 2, 0x7A09 in slot 8, 0x7E0A in slot 10; rs_active clear after slot 11; next line's slot 0 issues layer_addr0.
- Preload VRAM 0x7700..0x7705 = 1..6, hpulse -> obj_data = {3,2,1}; next 16-slot pass gives {6,5,4}; obj_addr=0x7706.
- CPU write cpu_addr=0x1234, din=0xBEEF -> single vram_we pulse at word 0x091A in slot 14, busy falls after slot 15; a later read of 0x1234 returns cpu_dout=0xBEEF.
- Second CPU edge while busy -> ignored, no second vram_we; reset asserted in slot 13 with rq=2 -> no write, busy=0 next clk.
- ce held low 10 clks mid-line -> slot, strobes and outputs frozen; vram_we never pulses.
